// File: rtl/aes_cipher_arb.sv
// aes_cipher_arb
// Round-robin arbiter sharing one AES cipher core between NUM_REQ requesters.
// A grant is held from the request handshake through the result handshake, so
// the core only ever works for one requester at a time. Also measures the
// latency (input handshake to output handshake) of each completed operation.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_valid_i/ready_o     per-requester request handshake
//   req_op_i                per-requester op (0 encrypt, 1 decrypt)
//   req_data_i              per-requester state, requester k at [k*DATA_W +: DATA_W]
//   rsp_valid_o/ready_i     per-requester result handshake (granted requester only)
//   rsp_data_o              result state, broadcast
//   cipher_*                handshakes and data to/from the cipher core
//   grant_o                 current / last granted requester
//   busy_o                  arbiter holds a grant
//   last_lat_o              latency of the last completed operation
module aes_cipher_arb #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 128,
  parameter int LAT_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ-1:0]         req_op_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  input  logic [NUM_REQ-1:0]         rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic                       cipher_in_valid_o,
  input  logic                       cipher_in_ready_i,
  output logic                       cipher_op_o,
  output logic [DATA_W-1:0]          cipher_data_o,
  input  logic                       cipher_out_valid_i,
  output logic                       cipher_out_ready_o,
  input  logic [DATA_W-1:0]          cipher_data_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o,
  output logic [LAT_W-1:0]           last_lat_o
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_BUSY = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]  last_lat_q, last_lat_d;

  logic [GW-1:0]     pick;
  logic [GW-1:0]     scan;
  logic              found;
  logic [LAT_W-1:0]  lat_inc;
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  // Per-requester data slices and one-hot handshake decode of the grant.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    assign data_arr[k]    = req_data_i[k*DATA_W +: DATA_W];
    assign req_ready_o[k] = (state_q == ARB_REQ) && (grant_q == GW'(k)) && cipher_in_ready_i;
    assign rsp_valid_o[k] = (state_q == ARB_BUSY) && (grant_q == GW'(k)) && cipher_out_valid_i;
  end

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ (which need not
  // be a power of two, hence the explicit wrap rather than natural overflow).
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    scan  = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid_i[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
      scan = (scan == GW'(NUM_REQ-1)) ? '0 : scan + 1'b1;
    end
  end

  assign lat_inc = (lat_cnt_q == {LAT_W{1'b1}}) ? lat_cnt_q : lat_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    lat_cnt_d  = lat_cnt_q;
    last_lat_d = last_lat_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req_valid_i) begin
          grant_d = pick;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        // A withdrawn request gives up the slot without moving the pointer.
        if (!req_valid_i[grant_q]) begin
          state_d = ARB_IDLE;
        end else if (cipher_in_ready_i) begin
          rr_ptr_d  = (grant_q == GW'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          lat_cnt_d = '0;
          state_d   = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        lat_cnt_d = lat_inc;
        if (cipher_out_valid_i && rsp_ready_i[grant_q]) begin
          last_lat_d = lat_inc;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      lat_cnt_q  <= '0;
      last_lat_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      lat_cnt_q  <= lat_cnt_d;
      last_lat_q <= last_lat_d;
    end
  end

  assign cipher_in_valid_o  = (state_q == ARB_REQ) && req_valid_i[grant_q];
  assign cipher_op_o        = (state_q == ARB_REQ) && req_op_i[grant_q];
  assign cipher_data_o      = (state_q == ARB_REQ) ? data_arr[grant_q] : '0;
  assign cipher_out_ready_o = (state_q == ARB_BUSY) && rsp_ready_i[grant_q];
  assign rsp_data_o         = (state_q == ARB_BUSY) ? cipher_data_i : '0;
  assign grant_o            = grant_q;
  assign busy_o             = (state_q != ARB_IDLE);
  assign last_lat_o         = last_lat_q;

endmodule

// File: tb/tb_aes_cipher_arb.sv
// Testbench for aes_cipher_arb (NUM_REQ=2, DATA_W=128, LAT_W=16).
// A behavioural cipher core answers after cip_lat cycles: encrypt returns the
// bitwise inverse, decrypt swaps the 64-bit halves. Expected results are hand
// computed constants pushed into a scoreboard when a request is accepted; a
// monitor pops on every result handshake and checks routing, data and latency.
module tb_aes_cipher_arb;

  logic         clk, rst;
  logic [1:0]   req_valid_i, req_ready_o, req_op_i, rsp_valid_o, rsp_ready_i;
  logic [255:0] req_data_i;
  logic [127:0] rsp_data_o, cipher_data_o, cipher_data_i;
  logic         cipher_in_valid_o, cipher_in_ready_i, cipher_op_o;
  logic         cipher_out_valid_i, cipher_out_ready_o, busy_o;
  logic [0:0]   grant_o;
  logic [15:0]  last_lat_o;

  aes_cipher_arb #(.NUM_REQ(2), .DATA_W(128), .LAT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_data_i(req_data_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .cipher_in_valid_o(cipher_in_valid_o),
    .cipher_in_ready_i(cipher_in_ready_i), .cipher_op_o(cipher_op_o),
    .cipher_data_o(cipher_data_o), .cipher_out_valid_i(cipher_out_valid_i),
    .cipher_out_ready_o(cipher_out_ready_o), .cipher_data_i(cipher_data_i),
    .grant_o(grant_o), .busy_o(busy_o), .last_lat_o(last_lat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int k; logic [127:0] data; int lat; } sb_t;
  sb_t sb[$];
  int  glog[$];
  int  n_chk = 0, n_pass = 0;
  bit  lat_pend = 0;
  int  pend_lat;
  int  cip_lat = 12;
  bit  cin_rdy_en = 1;

  localparam logic [127:0] D0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] D1 = 128'h01234567_89abcdef_fedcba98_76543210;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: timed out", name);
  endtask

  // Cipher core model: sample at negedge, update 1ns after posedge.
  initial begin : cipher_model
    bit cbusy, in_hs, out_hs, inop;
    int ccnt;
    logic [127:0] ind, cres;
    cbusy = 0; ccnt = 0; cres = '0;
    cipher_in_ready_i = 0; cipher_out_valid_i = 0; cipher_data_i = '0;
    forever begin
      @(negedge clk);
      in_hs  = cipher_in_valid_o && cipher_in_ready_i;
      out_hs = cipher_out_valid_i && cipher_out_ready_o;
      ind    = cipher_data_o;
      inop   = cipher_op_o;
      @(posedge clk); #1;
      if (rst) begin
        cbusy = 0; cipher_out_valid_i = 0; cipher_data_i = '0;
      end else if (out_hs) begin
        cbusy = 0; cipher_out_valid_i = 0; cipher_data_i = '0;
      end else if (in_hs) begin
        cbusy = 1;
        ccnt  = cip_lat - 1;
        cres  = inop ? {ind[63:0], ind[127:64]} : ~ind;
        if (ccnt == 0) begin cipher_out_valid_i = 1; cipher_data_i = cres; end
      end else if (cbusy && !cipher_out_valid_i) begin
        ccnt--;
        if (ccnt == 0) begin cipher_out_valid_i = 1; cipher_data_i = cres; end
      end
      cipher_in_ready_i = cin_rdy_en && !cbusy && !rst;
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clk);
      if (lat_pend) begin
        check("last_lat", 128'(last_lat_o), 128'(pend_lat));
        lat_pend = 0;
      end
      if (!rst && (rsp_valid_o & rsp_ready_i) != 2'b00) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rsp: got rsp_valid %b expected none", rsp_valid_o);
        end else begin
          e = sb.pop_front();
          check("rsp_valid", 128'(rsp_valid_o), 128'(2'b01 << e.k));
          check("rsp_data", rsp_data_o, e.data);
          pend_lat = e.lat;
          lat_pend = 1;
        end
      end
    end
  end

  // Present one request on requester k, hold until accepted, then queue the
  // expected result. waits = negedges seen before the handshake.
  task automatic issue(input int k, input bit op, input logic [127:0] data,
                       input logic [127:0] exp, input int lat, output int waits);
    sb_t e;
    req_op_i[k] = op;
    req_data_i[k*128 +: 128] = data;
    req_valid_i[k] = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (req_valid_i[k] && req_ready_o[k]) break;
      waits++;
      if (waits > 300) break;
    end
    if (waits > 300) begin
      fail_now($sformatf("issue_req%0d", k));
      req_valid_i[k] = 1'b0;
    end else begin
      glog.push_back(int'(grant_o));
      @(posedge clk); #1;
      req_valid_i[k] = 1'b0;
      e.k = k; e.data = exp; e.lat = lat;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || lat_pend) && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) fail_now(name);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int w, w0, w1, t;
    rst = 1; req_valid_i = '0; req_op_i = '0; req_data_i = '0; rsp_ready_i = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Idle after reset: everything quiet for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outputs",
            128'({req_ready_o, rsp_valid_o, cipher_in_valid_o, cipher_out_ready_o,
                  busy_o, grant_o, last_lat_o, cipher_op_o, |cipher_data_o, |rsp_data_o}),
            128'd0);
    end

    // Single request on requester 0, decrypt, 12-cycle core.
    @(posedge clk); #1;
    cip_lat = 12;
    issue(0, 1'b1, D0, 128'h8899aabb_ccddeeff_00112233_44556677, 12, w);
    check("req0_ready_delay", 128'(w), 128'd1);
    @(negedge clk);
    check("req0_ready_one_cycle", 128'(req_ready_o), 128'd0);
    drain("drain_single");

    // Result backpressure on requester 1, encrypt, 3-cycle core, 5 stall cycles.
    @(posedge clk); #1;
    cip_lat = 3;
    rsp_ready_i = 2'b01;
    issue(1, 1'b0, D1, 128'hfedcba98_76543210_01234567_89abcdef, 8, w);
    t = 0;
    @(negedge clk);
    while (!cipher_out_valid_i && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_now("wait_out_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("stall_out_ready", 128'(cipher_out_ready_o), 128'd0);
      check("stall_rsp_valid", 128'(rsp_valid_o), 128'(2'b10));
    end
    @(posedge clk); #1;
    rsp_ready_i = 2'b11;
    drain("drain_backpressure");

    // Fairness: both requesters continuously valid for 4 operations.
    @(posedge clk); #1;
    cip_lat = 4;
    glog.delete();
    fork
      begin
        issue(0, 1'b0, {4{32'hffff0000}}, {4{32'h0000ffff}}, 4, w0);
        issue(0, 1'b1, 128'h11111111_11111111_22222222_22222222,
              128'h22222222_22222222_11111111_11111111, 4, w0);
      end
      begin
        issue(1, 1'b1, 128'haaaaaaaa_aaaaaaaa_55555555_55555555,
              128'h55555555_55555555_aaaaaaaa_aaaaaaaa, 4, w1);
        issue(1, 1'b0, 128'h0, {128{1'b1}}, 4, w1);
      end
    join
    drain("drain_fair");
    check("fair_count", 128'(glog.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fair_grant%0d", i), 128'(glog[i]), 128'(i % 2));

    // One more op on requester 0 leaves the pointer at 1.
    @(posedge clk); #1;
    cip_lat = 2;
    issue(0, 1'b0, {16{8'hf0}}, {16{8'h0f}}, 2, w);
    drain("drain_pre_drop");

    // Requester 1 withdraws while the core is not ready.
    cin_rdy_en = 0;
    repeat (2) @(posedge clk);
    #1;
    req_op_i[1] = 1'b1;
    req_data_i[255:128] = {4{32'hdeadbeef}};
    req_valid_i[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drop_grant", 128'(grant_o), 128'd1);
    check("drop_in_valid", 128'(cipher_in_valid_o), 128'd1);
    check("drop_op", 128'(cipher_op_o), 128'd1);
    check("drop_data", cipher_data_o, {4{32'hdeadbeef}});
    check("drop_req_ready", 128'(req_ready_o), 128'd0);
    @(posedge clk); #1;
    req_valid_i[1] = 1'b0;
    @(negedge clk);
    check("drop_in_valid_low", 128'(cipher_in_valid_o), 128'd0);
    @(negedge clk);
    check("drop_back_idle", 128'({busy_o, |cipher_data_o}), 128'd0);
    cin_rdy_en = 1;
    @(posedge clk); #2;
    glog.delete();
    cip_lat = 3;
    fork
      issue(1, 1'b0, 128'h1, {{127{1'b1}}, 1'b0}, 3, w1);
      issue(0, 1'b1, 128'h2, 128'h00000000_00000002_00000000_00000000, 3, w0);
    join
    drain("drain_after_drop");
    check("ptr_kept_first", 128'(glog[0]), 128'd1);
    check("ptr_kept_second", 128'(glog[1]), 128'd0);

    // Asynchronous reset in the middle of a busy operation.
    @(posedge clk); #1;
    cip_lat = 20;
    issue(0, 1'b0, D0, ~D0, 0, w);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 128'(busy_o), 128'd1);
    #2 rst = 1;
    #1;
    check("rst_async_outputs",
          128'({busy_o, rsp_valid_o, cipher_out_ready_o, grant_o, last_lat_o, |rsp_data_o}),
          128'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    cip_lat = 5;
    issue(1, 1'b1, D0, 128'h8899aabb_ccddeeff_00112233_44556677, 5, w);
    drain("drain_after_rst");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
